// File: rtl/comp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comp_pkg
// Brief    : Shared constants, state encoding and sign extension for comp_accum
// Revision : 1.0
// ============================================================================
package comp_pkg;

   localparam int COMP_W = 8;
   localparam int EXT_W  = 32;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Callers narrow the result to their accumulator width with a size cast.
   function automatic logic [EXT_W-1:0] sext(input logic [COMP_W-1:0] v);
      return {{(EXT_W-COMP_W){v[COMP_W-1]}}, v};
   endfunction

endpackage
`default_nettype wire

// File: rtl/comp_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : comp_sat_add
// Brief    : Signed ACC_W-bit adder with step-overflow detect; clamps on
//            overflow when COMP_ACCUM_SAT_EN is defined, wraps otherwise.
// Revision : 1.0
// ============================================================================
module comp_sat_add #(
   parameter int ACC_W = 10
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] samp,
   output logic [ACC_W-1:0] sum,
   output logic             step_ovf
);

   logic [ACC_W-1:0] w_raw;

   assign w_raw    = acc + samp;
   assign step_ovf = (acc[ACC_W-1] == samp[ACC_W-1]) && (w_raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef COMP_ACCUM_SAT_EN
   // Operands share a sign on overflow, so the accumulator sign picks the rail.
   always_comb begin
      sum = w_raw;
      if (step_ovf) begin
         sum = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   assign sum = w_raw;
`endif

endmodule
`default_nettype wire

// File: rtl/comp_accum.sv
`default_nettype none
// ============================================================================
// Module   : comp_accum
// Brief    : Sums blocks of N_SAMP signed bytes into an ACC_W-bit total with a
//            held result handshake. Define COMP_ACCUM_SAT_EN for saturation.
// Revision : 1.0
// ============================================================================
module comp_accum
   import comp_pkg::*;
#(
   parameter int N_SAMP = 16,
   parameter int ACC_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [COMP_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  sum_out,
   output logic              ovf,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int               CNT_W    = $clog2(N_SAMP);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMP - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf_stk;
   logic [ACC_W-1:0]  r_sum;
   logic              r_ovf;
   logic              r_out_valid;

   logic [ACC_W-1:0]  w_ext;
   logic [ACC_W-1:0]  w_sum;
   logic              w_step_ovf;
   logic              w_accept;
   logic              w_last;

   assign w_ext    = ACC_W'(sext(in_data));
   assign in_ready = (r_state == ACCUM);
   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_cnt == LAST_CNT);

   comp_sat_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .acc      (r_acc),
      .samp     (w_ext),
      .sum      (w_sum),
      .step_ovf (w_step_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ACCUM;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM:   if (!clr && w_accept && w_last) w_state_nxt = HOLD;
         HOLD:    if (out_ready)                  w_state_nxt = ACCUM;
         default: w_state_nxt = ACCUM;
      endcase
   end

   // clr only affects the partial block; a presented result is never dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf_stk   <= 1'b0;
         r_sum       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (r_state == ACCUM) begin
         if (clr) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_stk <= 1'b0;
         end else if (w_accept) begin
            if (w_last) begin
               r_sum       <= w_sum;
               r_ovf       <= r_ovf_stk | w_step_ovf;
               r_out_valid <= 1'b1;
               r_acc       <= '0;
               r_cnt       <= '0;
               r_ovf_stk   <= 1'b0;
            end else begin
               r_acc     <= w_sum;
               r_cnt     <= r_cnt + 1'b1;
               r_ovf_stk <= r_ovf_stk | w_step_ovf;
            end
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign sum_out   = r_sum;
   assign ovf       = r_ovf;
   assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_comp_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_comp_accum
// Brief    : Directed and random stimulus against an integer block-sum model.
// Revision : 1.0
// ============================================================================
module tb_comp_accum;

   localparam int N_SAMP = 16;
   localparam int ACC_W  = 10;
   localparam int MAXV   = (1 << (ACC_W - 1)) - 1;
   localparam int MINV   = -(1 << (ACC_W - 1));
   localparam int MOD    = 1 << ACC_W;
   localparam int MASK   = MOD - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clr = 1'b0;
   logic [7:0]       in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [ACC_W-1:0] sum_out;
   logic             ovf;
   logic             out_valid;
   logic             out_ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: running integer sum of the current block plus the held result.
   bit m_hold, m_ov, m_ovf, m_stk;
   int m_acc, m_cnt, m_sum;

   comp_accum #(
      .N_SAMP (N_SAMP),
      .ACC_W  (ACC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_out   (sum_out),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hold = 0; m_ov = 0; m_ovf = 0; m_stk = 0;
      m_acc = 0; m_cnt = 0; m_sum = 0;
   endtask

   task automatic model_clock(input logic v, input logic [7:0] d, input logic c,
                              input logic r, input logic ordy);
      int t;
      if (r) begin
         model_reset();
      end else if (!m_hold) begin
         if (c) begin
            m_acc = 0; m_cnt = 0; m_stk = 0;
         end else if (v) begin
            t = m_acc + int'($signed(d));
            if (t > MAXV || t < MINV) begin
               m_stk = 1;
`ifdef COMP_ACCUM_SAT_EN
               t = (t > MAXV) ? MAXV : MINV;
`else
               while (t > MAXV) t -= MOD;
               while (t < MINV) t += MOD;
`endif
            end
            m_acc = t;
            m_cnt++;
            if (m_cnt == N_SAMP) begin
               m_sum = m_acc; m_ovf = m_stk; m_hold = 1; m_ov = 1;
               m_acc = 0; m_cnt = 0; m_stk = 0;
            end
         end
      end else if (ordy) begin
         m_hold = 0; m_ov = 0;
      end
   endtask

   // Drive one cycle: compare outputs mid-cycle, then advance the model to the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic c,
                       input logic r, input logic ordy);
      in_valid = v; in_data = d; clr = c; rst = r; out_ready = ordy;
      @(negedge clk);
      check("in_ready", in_ready, !m_hold);
      check("out_valid", out_valid, m_ov);
      check("sum_out", sum_out, m_sum & MASK);
      check("ovf", ovf, m_ovf);
      model_clock(v, d, c, r, ordy);
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n, input logic [7:0] d, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b1, d, 1'b0, 1'b0, ordy);
   endtask

   task automatic drain();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // reset state
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // block of +1
      feed(N_SAMP, 8'h01, 1'b1);
      check("t1_valid", out_valid, 1'b1);
      check("t1_sum", sum_out, 10'h010);
      check("t1_ovf", ovf, 1'b0);
      drain();

      // block of -1
      feed(N_SAMP, 8'hFF, 1'b1);
      check("t2_sum", sum_out, 10'h3F0);
      check("t2_ovf", ovf, 1'b0);
      drain();

      // block of +127 overflows
      feed(N_SAMP, 8'h7F, 1'b1);
`ifdef COMP_ACCUM_SAT_EN
      check("t3_sum", sum_out, 10'h1FF);
`else
      check("t3_sum", sum_out, 10'h3F0);
`endif
      check("t3_ovf", ovf, 1'b1);
      drain();

      // backpressure: the held sample 0x33 must open the next block
      feed(N_SAMP, 8'h01, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      check("t4_ready", in_ready, 1'b0);
      check("t4_sum", sum_out, 10'h010);
      step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
      check("t4_ready_after", in_ready, 1'b1);
      feed(1, 8'h33, 1'b1);
      feed(N_SAMP - 1, 8'h01, 1'b1);
      check("t4_next_sum", sum_out, 10'h042);
      drain();

      // mid-block abort
      feed(7, 8'h05, 1'b1);
      step(1'b1, 8'h05, 1'b1, 1'b0, 1'b1);
      feed(N_SAMP, 8'h02, 1'b1);
      check("t5_sum", sum_out, 10'h020);
      drain();

      // reset while holding, then reset mid-block
      feed(N_SAMP, 8'h01, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("t6_valid", out_valid, 1'b0);
      check("t6_sum", sum_out, 10'h000);
      feed(3, 8'h01, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      feed(N_SAMP, 8'h80, 1'b1);
`ifdef COMP_ACCUM_SAT_EN
      check("t6_min_sum", sum_out, 10'h200);
`else
      check("t6_min_sum", sum_out, 10'h000);
`endif
      check("t6_min_ovf", ovf, 1'b1);
      drain();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
              8'($urandom),
              ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
              ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
